pe_op_sequencer: RTL and testbench
==================================

// Module: pe_op_sequencer
// PURPOSE
// - Sequences one or more lock-stepped processing_element lanes through a vector operation.
// - Accepts one command (opcode + element count) over a valid/ready handshake.
// - Per beat, drives the PE mux/enable controls and a writeback strobe; pulses done at the end.
// - Sits between the vector issue logic and the PE array; the operand fetch unit follows elem_idx.
// PARAMETERS
// - MAX_LEN      64                     max elements per command
// - LEN_W        $clog2(MAX_LEN+1)      width of cmd_len / elem_idx
// - TREE_STAGES  3                      reduction-tree adder levels (log2 lanes), >=1
// PORTS
// - clk         in   1      single clock, rising edge
// - reset       in   1      synchronous, active-high
// - cmd_valid   in   1      command offered
// - cmd_ready   out  1      high only in IDLE
// - cmd_op      in   3      op_e: ADD=0 MUL=1 MACC=2 RELU=3 REDSUM=4; 5-7 illegal
// - cmd_len     in   LEN_W  element beats, 0..MAX_LEN
// - src_valid   in   1      operands a/b/c valid this cycle; low = stall
// - mux_add_a   out  2      to PE
// - mux_add_b   out  2      to PE
// - mux_c_acc   out  1      to PE
// - mux_sat8    out  2      to PE
// - mux_relu    out  1      to PE
// - mux_res     out  2      to PE
// - mux_comb    out  1      to PE
// - enable_acc  out  1      to PE
// - elem_idx    out  LEN_W  current beat index, 0-based
// - wb_valid    out  1      PE r output is a result this cycle
// - done        out  1      one-cycle pulse, command complete
// - err_op      out  1      one-cycle pulse, illegal opcode dropped
// BEHAVIOUR
// - Reset:
//   - state=IDLE, elem_idx=0, cmd_ready=1.
//   - All mux/enable outputs are 0; wb_valid, done and err_op are 0.
//   - Reset mid-command abandons it with no done pulse; PE acc_reg is not touched.
// - Handshake: command accepted when cmd_valid&cmd_ready; op and len registered; EXEC next cycle.
// - Zero length: len=0 -> done pulses the cycle after accept, no wb_valid.
// - Illegal op: err_op pulses the cycle after accept; stays in IDLE.
// - States: IDLE -> EXEC -> [TREE] -> [WB] -> IDLE.
// - Outputs are decoded combinationally from registered state/op/idx and src_valid.
// - EXEC:
//   - A beat fires when src_valid=1; elem_idx increments.
//   - src_valid=0 forces enable_acc=0 and wb_valid=0; elem_idx holds.
//   - The last beat (idx=len-1) moves to the next state.
// - Per-op EXEC controls (unlisted = 0):
//   - ADD:    add_a=0, add_b=0, sat8=2, res=2, comb=1; wb_valid per beat.
//   - MUL:    res=0, comb=1; wb_valid per beat.
//   - RELU:   relu=0, res=3, comb=1; wb_valid per beat.
//   - MACC:   add_a=1, add_b=1, res=1, enable_acc=1; c_acc=0 on beat 0 (c = init), else 1.
//   - REDSUM: add_a=0, add_b=1, res=1, enable_acc=1; c_acc rule as MACC.
// - Next state after the last beat:
//   - MACC -> WB.
//   - REDSUM -> TREE.
//   - Elementwise ops -> IDLE with done pulsed the same cycle as the last beat.
// - TREE: exactly TREE_STAGES cycles, ignores src_valid; add_a=2, add_b=2, res=1, enable_acc=1.
// - WB: 1 cycle; comb=0, wb_valid=1, done=1 -> IDLE.
// - Back-to-back: cmd_ready rises the cycle after done, so at most one command every len+1 cycles.
// - Arithmetic: none in datapath; elem_idx never exceeds len-1; no wrap is possible.
// STRUCTURE
// - Package ava_pe_pkg holds:
//   - op_e enum.
//   - Localparams for the PE select codes (ADD_A_MUL=1, RES_SAT8=2, ...).
//   - pe_ctrl_t struct bundling the 8 PE control fields.
// - Sub-module pe_ctrl_decode (combinational): {op, phase, first_beat, src_valid} -> pe_ctrl_t.
// - The top holds the FSM and counters only.
// TESTING
// 1. Reset held 3 cycles mid-MACC len=8:
//    - next cycle cmd_ready=1, all controls 0, no done.
// 2. ADD len=4, src_valid constant 1:
//    - wb_valid on 4 consecutive cycles, elem_idx 0..3, done on 4th, cmd_ready next cycle.
// 3. MACC len=3, a={2,3,4}<<4 pattern, b=16, c=5, with src_valid dropped for 2 cycles after beat 1:
//    - enable_acc=0 during the stall; c_acc=0 only on beat 0.
//    - WB cycle mux_comb=0; r = 5+2+3+4 = 14.
// 4. REDSUM len=2, TREE_STAGES=3:
//    - exactly 3 TREE cycles with add_a=add_b=2, then a 1-cycle WB with done.
//    - Total 6 cycles accept-to-done.
// 5. Corner cases:
//    - cmd_len=0 -> done 1 cycle after accept, no wb_valid.
//    - cmd_op=6 -> err_op pulse, no done, cmd_ready stays 1.
// 6. Back-to-back RELU len=1 then MUL len=1:
//    - second accept the cycle after the first done.
//    - mux_res 3 then 0.

Source files
------------

// File: rtl/ava_pe_pkg.sv
// Shared types and PE select codes for the vector-op sequencer and its control decoder.
package ava_pe_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_MUL    = 3'd1,
    OP_MACC   = 3'd2,
    OP_RELU   = 3'd3,
    OP_REDSUM = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_EXEC = 2'd1,
    PH_TREE = 2'd2,
    PH_WB   = 2'd3
  } phase_e;

  localparam logic [1:0] ADD_A_SRC  = 2'd0;
  localparam logic [1:0] ADD_A_MUL  = 2'd1;
  localparam logic [1:0] ADD_A_TREE = 2'd2;
  localparam logic [1:0] ADD_B_SRC  = 2'd0;
  localparam logic [1:0] ADD_B_ACC  = 2'd1;
  localparam logic [1:0] ADD_B_TREE = 2'd2;
  localparam logic       C_ACC_INIT = 1'b0;
  localparam logic       C_ACC_ACC  = 1'b1;
  localparam logic [1:0] SAT8_ON    = 2'd2;
  localparam logic [1:0] RES_MUL    = 2'd0;
  localparam logic [1:0] RES_ADD    = 2'd1;
  localparam logic [1:0] RES_SAT8   = 2'd2;
  localparam logic [1:0] RES_RELU   = 2'd3;
  localparam logic       COMB_ACC   = 1'b0;
  localparam logic       COMB_RES   = 1'b1;

  typedef struct packed {
    logic [1:0] add_a;
    logic [1:0] add_b;
    logic       c_acc;
    logic [1:0] sat8;
    logic       relu;
    logic [1:0] res;
    logic       comb;
    logic       enable_acc;
  } pe_ctrl_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/pe_ctrl_decode.sv
// Combinational decode of sequencer phase/op/beat into the PE mux and enable controls.
module pe_ctrl_decode
  import ava_pe_pkg::*;
(
  input  op_e      op,
  input  phase_e   phase,
  input  logic     first_beat,
  input  logic     src_valid,
  output pe_ctrl_t ctrl,
  output logic     wb_valid
);

  always_comb begin
    ctrl     = '0;
    wb_valid = 1'b0;
    case (phase)
      PH_EXEC: begin
        case (op)
          OP_ADD: begin
            ctrl.add_a = ADD_A_SRC;
            ctrl.add_b = ADD_B_SRC;
            ctrl.sat8  = SAT8_ON;
            ctrl.res   = RES_SAT8;
            ctrl.comb  = COMB_RES;
            wb_valid   = src_valid;
          end
          OP_MUL: begin
            ctrl.res  = RES_MUL;
            ctrl.comb = COMB_RES;
            wb_valid  = src_valid;
          end
          OP_RELU: begin
            ctrl.res  = RES_RELU;
            ctrl.comb = COMB_RES;
            wb_valid  = src_valid;
          end
          OP_MACC, OP_REDSUM: begin
            // first beat seeds the accumulator from c instead of acc_reg
            ctrl.add_a      = (op == OP_MACC) ? ADD_A_MUL : ADD_A_SRC;
            ctrl.add_b      = ADD_B_ACC;
            ctrl.res        = RES_ADD;
            ctrl.c_acc      = first_beat ? C_ACC_INIT : C_ACC_ACC;
            ctrl.enable_acc = src_valid;
          end
          default: ;
        endcase
      end
      PH_TREE: begin
        ctrl.add_a      = ADD_A_TREE;
        ctrl.add_b      = ADD_B_TREE;
        ctrl.res        = RES_ADD;
        ctrl.enable_acc = 1'b1;
      end
      PH_WB: begin
        ctrl.comb = COMB_ACC;
        wb_valid  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pe_op_sequencer.sv
// Command FSM and beat/tree counters driving lock-stepped PE lanes through one vector op.
module pe_op_sequencer
  import ava_pe_pkg::*;
#(
  parameter int MAX_LEN     = 64,
  parameter int LEN_W       = $clog2(MAX_LEN + 1),
  parameter int TREE_STAGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             src_valid,
  output logic [1:0]       mux_add_a,
  output logic [1:0]       mux_add_b,
  output logic             mux_c_acc,
  output logic [1:0]       mux_sat8,
  output logic             mux_relu,
  output logic [1:0]       mux_res,
  output logic             mux_comb,
  output logic             enable_acc,
  output logic [LEN_W-1:0] elem_idx,
  output logic             wb_valid,
  output logic             done,
  output logic             err_op
);

  localparam int TC_W = $clog2(TREE_STAGES + 1);

  phase_e           state_q, state_d;
  op_e              op_q;
  logic [LEN_W-1:0] len_q, idx_q, idx_d;
  logic [TC_W-1:0]  tree_q, tree_d;
  logic             zdone_q, err_q;
  logic             accept, last_beat, last_tree, done_exec;
  pe_ctrl_t         ctrl;

  // zero-length done cycle also blocks a new accept, keeping one idle cycle after every done
  assign cmd_ready = (state_q == PH_IDLE) && !zdone_q;
  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = idx_q == len_q - LEN_W'(1);
  assign last_tree = tree_q == TC_W'(TREE_STAGES - 1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tree_d    = tree_q;
    done_exec = 1'b0;
    case (state_q)
      PH_IDLE: if (accept && op_legal(cmd_op) && cmd_len != '0) state_d = PH_EXEC;
      PH_EXEC: if (src_valid) begin
        if (last_beat) begin
          idx_d = '0;
          case (op_q)
            OP_MACC:   state_d = PH_WB;
            OP_REDSUM: state_d = PH_TREE;
            default: begin
              state_d   = PH_IDLE;
              done_exec = 1'b1;
            end
          endcase
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      PH_TREE: if (last_tree) begin
        tree_d  = '0;
        state_d = PH_WB;
      end else begin
        tree_d = tree_q + TC_W'(1);
      end
      PH_WB:   state_d = PH_IDLE;
      default: state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PH_IDLE;
      op_q    <= OP_ADD;
      len_q   <= '0;
      idx_q   <= '0;
      tree_q  <= '0;
      zdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tree_q  <= tree_d;
      zdone_q <= accept && op_legal(cmd_op) && cmd_len == '0;
      err_q   <= accept && !op_legal(cmd_op);
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        len_q <= cmd_len;
      end
    end
  end

  pe_ctrl_decode u_dec (
    .op        (op_q),
    .phase     (state_q),
    .first_beat(idx_q == '0),
    .src_valid (src_valid),
    .ctrl      (ctrl),
    .wb_valid  (wb_valid)
  );

  assign mux_add_a  = ctrl.add_a;
  assign mux_add_b  = ctrl.add_b;
  assign mux_c_acc  = ctrl.c_acc;
  assign mux_sat8   = ctrl.sat8;
  assign mux_relu   = ctrl.relu;
  assign mux_res    = ctrl.res;
  assign mux_comb   = ctrl.comb;
  assign enable_acc = ctrl.enable_acc;
  assign elem_idx   = idx_q;
  assign done       = done_exec || (state_q == PH_WB) || zdone_q;
  assign err_op     = err_q;

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Directed bench for pe_op_sequencer: scoreboard of writeback/done/err events plus per-cycle control checks.
module tb_pe_op_sequencer;

  localparam int MAX_LEN     = 64;
  localparam int LEN_W       = $clog2(MAX_LEN + 1);
  localparam int TREE_STAGES = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             src_valid;
  logic [1:0]       mux_add_a, mux_add_b, mux_sat8, mux_res;
  logic             mux_c_acc, mux_relu, mux_comb, enable_acc;
  logic [LEN_W-1:0] elem_idx;
  logic             wb_valid, done, err_op;
  logic [13:0]      ctrl_all;

  always #5 clk = ~clk;

  pe_op_sequencer #(.MAX_LEN(MAX_LEN), .TREE_STAGES(TREE_STAGES)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .src_valid(src_valid),
    .mux_add_a(mux_add_a), .mux_add_b(mux_add_b), .mux_c_acc(mux_c_acc),
    .mux_sat8(mux_sat8), .mux_relu(mux_relu), .mux_res(mux_res),
    .mux_comb(mux_comb), .enable_acc(enable_acc), .elem_idx(elem_idx),
    .wb_valid(wb_valid), .done(done), .err_op(err_op)
  );

  assign ctrl_all = {mux_add_a, mux_add_b, mux_c_acc, mux_sat8, mux_relu,
                     mux_res, mux_comb, enable_acc, wb_valid, done};

  // single-lane PE accumulator: product is a*b in Q8 fixed point, seeded from c when c_acc=0
  int a_op = 0, b_op = 16, c_op = 5, acc = 0;
  always @(posedge clk) if (enable_acc === 1'b1) acc <= (mux_c_acc ? acc : c_op) + (a_op * b_op) / 256;

  typedef struct {
    logic wb;
    logic done;
    logic err;
    int   idx;
    int   res;
    int   comb;
  } exp_t;
  exp_t sb[$];

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic wb, input logic dn, input logic er,
                           input int idx, input int res, input int comb);
    exp_t e;
    e = '{wb, dn, er, idx, res, comb};
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (wb_valid !== 1'b0 || done !== 1'b0 || err_op !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {29'd0, wb_valid, done, err_op}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_wb",   32'(wb_valid), 32'(e.wb));
        chk("sb_done", 32'(done),     32'(e.done));
        chk("sb_err",  32'(err_op),   32'(e.err));
        if (e.wb) begin
          chk("sb_idx",  32'(elem_idx), e.idx);
          chk("sb_res",  32'(mux_res),  e.res);
          chk("sb_comb", 32'(mux_comb), e.comb);
        end
      end
    end
  endtask

  task automatic settle();
    #4;
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input int len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    settle();
    chk("accept_ready", cmd_ready, 1);
    adv();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; src_valid = 1'b0;
    adv(); adv();
    reset = 1'b0;
    settle();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ctrl", ctrl_all, 0);
    chk("rst_idx", elem_idx, 0);
    chk("rst_err", err_op, 0);
    adv();

    // reset in the middle of a MACC abandons it silently
    send(3'd2, 8);
    src_valid = 1'b1;
    repeat (3) begin settle(); adv(); end
    src_valid = 1'b0;
    reset = 1'b1;
    repeat (3) begin settle(); adv(); end
    reset = 1'b0;
    settle();
    chk("t1_ready", cmd_ready, 1);
    chk("t1_ctrl", ctrl_all, 0);
    chk("t1_idx", elem_idx, 0);
    adv();

    // ADD len=4, no stalls
    for (int i = 0; i < 4; i++) expect_ev(1'b1, i == 3, 1'b0, i, 2, 1);
    send(3'd0, 4);
    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_busy", cmd_ready, 0);
      chk("t2_sat8", mux_sat8, 2);
      adv();
    end
    src_valid = 1'b0;
    settle();
    chk("t2_ready_after", cmd_ready, 1);
    adv();

    // MACC len=3 with a two-cycle stall after beat 1
    c_op = 5; b_op = 16;
    expect_ev(1'b1, 1'b1, 1'b0, 0, 0, 0);
    send(3'd2, 3);
    src_valid = 1'b1; a_op = 2 << 4;
    settle();
    chk("t3_b0_en", enable_acc, 1);
    chk("t3_b0_cacc", mux_c_acc, 0);
    chk("t3_b0_adda", mux_add_a, 1);
    chk("t3_b0_addb", mux_add_b, 1);
    chk("t3_b0_res", mux_res, 1);
    adv();
    a_op = 3 << 4;
    settle();
    chk("t3_b1_cacc", mux_c_acc, 1);
    chk("t3_b1_idx", elem_idx, 1);
    adv();
    src_valid = 1'b0;
    repeat (2) begin
      settle();
      chk("t3_stall_en", enable_acc, 0);
      chk("t3_stall_idx", elem_idx, 2);
      adv();
    end
    src_valid = 1'b1; a_op = 4 << 4;
    settle();
    chk("t3_b2_en", enable_acc, 1);
    chk("t3_b2_cacc", mux_c_acc, 1);
    adv();
    src_valid = 1'b0;
    settle();
    chk("t3_r", acc, 14);
    adv();
    settle();
    chk("t3_ready_after", cmd_ready, 1);
    adv();

    // REDSUM len=2: two beats, three tree cycles, one WB (done 6 cycles after accept)
    expect_ev(1'b1, 1'b1, 1'b0, 0, 0, 0);
    send(3'd4, 2);
    src_valid = 1'b1;
    settle();
    chk("t4_b0_adda", mux_add_a, 0);
    chk("t4_b0_addb", mux_add_b, 1);
    chk("t4_b0_cacc", mux_c_acc, 0);
    adv();
    settle();
    chk("t4_b1_cacc", mux_c_acc, 1);
    adv();
    src_valid = 1'b0;
    for (int t = 0; t < TREE_STAGES; t++) begin
      settle();
      chk("t4_tree_adda", mux_add_a, 2);
      chk("t4_tree_addb", mux_add_b, 2);
      chk("t4_tree_en", enable_acc, 1);
      chk("t4_tree_done", done, 0);
      adv();
    end
    settle();
    chk("t4_wb_done", done, 1);
    adv();

    // zero length and illegal opcode
    expect_ev(1'b0, 1'b1, 1'b0, 0, 0, 0);
    send(3'd0, 0);
    settle();
    chk("t5_zlen_wb", wb_valid, 0);
    adv();
    settle(); adv();
    expect_ev(1'b0, 1'b0, 1'b1, 0, 0, 0);
    send(3'd6, 3);
    settle();
    chk("t5_err_ready", cmd_ready, 1);
    chk("t5_err_done", done, 0);
    adv();
    settle();
    chk("t5_err_idle", cmd_ready, 1);
    adv();

    // back-to-back RELU then MUL, second offer held while busy
    expect_ev(1'b1, 1'b1, 1'b0, 0, 3, 1);
    expect_ev(1'b1, 1'b1, 1'b0, 0, 0, 1);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_len = LEN_W'(1);
    settle();
    chk("t6_acc1", cmd_ready, 1);
    adv();
    cmd_op = 3'd1; src_valid = 1'b1;
    settle();
    chk("t6_busy", cmd_ready, 0);
    chk("t6_res_relu", mux_res, 3);
    adv();
    settle();
    chk("t6_acc2", cmd_ready, 1);
    adv();
    cmd_valid = 1'b0;
    settle();
    chk("t6_res_mul", mux_res, 0);
    adv();
    src_valid = 1'b0;
    repeat (3) begin settle(); adv(); end

    chk("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
